// File: rtl/cmac_block_fetcher_if.sv
// Bundle between the block fetcher, the message RAM read port and the CMAC core.
// blk_*: a block transfers on a rising clk edge where blk_valid & blk_ready are both 1.
// Once blk_valid is raised it stays up, with blk_data/blk_last/blk_complete frozen, until
// that transfer. blk_ready may change freely. ram_* is a plain pipelined read:
// ram_rdata is valid RD_LAT cycles after ram_en.
interface cmac_block_fetcher_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 9
);
   logic              ram_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rdata;
   logic              blk_valid;
   logic              blk_ready;
   logic [DATA_W-1:0] blk_data;
   logic              blk_last;
   logic              blk_complete;

   modport master (
      output ram_en, ram_addr,
      input  ram_rdata,
      output blk_valid, blk_data, blk_last, blk_complete,
      input  blk_ready
   );

   modport slave (
      input  ram_en, ram_addr,
      output ram_rdata,
      input  blk_valid, blk_data, blk_last, blk_complete,
      output blk_ready
   );
endinterface

// File: rtl/cmac_block_fetcher.sv
// Message-block sequencer: reads a bit-length message from RAM, applies 10* padding to a
// partial tail block and streams blocks to the CMAC core through a credit-limited FIFO.
module cmac_block_fetcher #(
   parameter int DATA_W     = 128,
   parameter int ADDR_W     = 9,
   parameter int LEN_W      = 16,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LEN_W-1:0]     len,
   input  logic [ADDR_W-1:0]    base_addr,
   cmac_block_fetcher_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           dbg_state
);
   localparam int LOG_DW = $clog2(DATA_W);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int NBLK_W = LEN_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [NBLK_W-1:0]     nblk_q, nblk_d, idx_q, idx_d;
   logic [LOG_DW-1:0]     res_q, res_d;
   logic                  complete_q, complete_d, len_zero_q, len_zero_d;
   logic [ADDR_W-1:0]     base_q, base_d, ram_addr_q, ram_addr_d;
   logic                  ram_en_q, ram_en_d, en_last_q, en_last_d;
   logic [RD_LAT-1:0]     vld_q, vld_d, tag_q, tag_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, occ_q, occ_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
   logic [DATA_W-1:0]     fifo_data_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d, fifo_cmp_q, fifo_cmp_d;

   logic [NBLK_W-1:0]     nblk_calc;
   logic                  fifo_valid, pop, issue, issue_last, direct_push;
   logic                  push, push_last;
   logic [DATA_W-1:0]     push_raw, push_data, pad_mask, pad_bit;

   assign fifo_valid = (occ_q != '0);
   assign pop        = fifo_valid & bus.blk_ready;
   assign issue_last = (idx_q == nblk_q - NBLK_W'(1));

   always_comb begin
      nblk_calc = ({1'b0, len} + NBLK_W'(DATA_W - 1)) >> LOG_DW;
      if (len == '0) nblk_calc = NBLK_W'(1);
   end

   // cnt_q is the credit: reads decided but not yet popped, so FIFO + pipeline never overfill.
   always_comb begin
      state_d     = state_q;
      nblk_d      = nblk_q;
      idx_d       = idx_q;
      res_d       = res_q;
      complete_d  = complete_q;
      len_zero_d  = len_zero_q;
      base_d      = base_q;
      ram_en_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      en_last_d   = 1'b0;
      issue       = 1'b0;
      direct_push = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_FETCH;
               nblk_d     = nblk_calc;
               idx_d      = '0;
               res_d      = len[LOG_DW-1:0];
               len_zero_d = (len == '0);
               complete_d = (len != '0) && (len[LOG_DW-1:0] == '0);
               base_d     = base_addr;
            end
         end
         S_FETCH: begin
            if (len_zero_q) begin
               direct_push = 1'b1;
               state_d     = S_DRAIN;
            end else if (pop || (cnt_q < CNT_W'(FIFO_DEPTH))) begin
               issue      = 1'b1;
               ram_en_d   = 1'b1;
               ram_addr_d = base_q + idx_q[ADDR_W-1:0];
               en_last_d  = issue_last;
               idx_d      = idx_q + NBLK_W'(1);
               if (issue_last) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && fifo_last_q[rd_ptr_q]) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The last/pad tag travels with each read so the tail is padded on its way into the FIFO.
   always_comb begin
      vld_d[0] = ram_en_q;
      tag_d[0] = en_last_q;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         tag_d[i] = tag_q[i-1];
      end
      push      = vld_q[RD_LAT-1] | direct_push;
      push_last = tag_q[RD_LAT-1] | direct_push;
      push_raw  = direct_push ? '0 : bus.ram_rdata;
      pad_mask  = ~({DATA_W{1'b1}} >> res_q);
      pad_bit   = {1'b1, {(DATA_W-1){1'b0}}} >> res_q;
      push_data = (push_last && !complete_q) ? ((push_raw & pad_mask) | pad_bit) : push_raw;
   end

   always_comb begin
      cnt_d       = cnt_q;
      occ_d       = occ_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      fifo_cmp_d  = fifo_cmp_q;
      if ((issue || direct_push) && !pop) cnt_d = cnt_q + CNT_W'(1);
      else if (!(issue || direct_push) && pop) cnt_d = cnt_q - CNT_W'(1);
      if (push && !pop) occ_d = occ_q + CNT_W'(1);
      else if (!push && pop) occ_d = occ_q - CNT_W'(1);
      if (push) begin
         fifo_data_d[wr_ptr_q] = push_data;
         fifo_last_d[wr_ptr_q] = push_last;
         fifo_cmp_d[wr_ptr_q]  = push_last & complete_q;
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         nblk_q      <= '0;
         idx_q       <= '0;
         res_q       <= '0;
         complete_q  <= 1'b0;
         len_zero_q  <= 1'b0;
         base_q      <= '0;
         ram_en_q    <= 1'b0;
         ram_addr_q  <= '0;
         en_last_q   <= 1'b0;
         vld_q       <= '0;
         tag_q       <= '0;
         cnt_q       <= '0;
         occ_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_last_q <= '0;
         fifo_cmp_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         nblk_q      <= nblk_d;
         idx_q       <= idx_d;
         res_q       <= res_d;
         complete_q  <= complete_d;
         len_zero_q  <= len_zero_d;
         base_q      <= base_d;
         ram_en_q    <= ram_en_d;
         ram_addr_q  <= ram_addr_d;
         en_last_q   <= en_last_d;
         vld_q       <= vld_d;
         tag_q       <= tag_d;
         cnt_q       <= cnt_d;
         occ_q       <= occ_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_last_q <= fifo_last_d;
         fifo_cmp_q  <= fifo_cmp_d;
         fifo_data_q <= fifo_data_d;
      end
   end

   assign bus.ram_en       = ram_en_q;
   assign bus.ram_addr     = ram_addr_q;
   assign bus.blk_valid    = fifo_valid;
   assign bus.blk_data     = fifo_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign bus.blk_last     = fifo_valid & fifo_last_q[rd_ptr_q];
   assign bus.blk_complete = fifo_valid & fifo_cmp_q[rd_ptr_q];
   assign busy             = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign done             = (state_q == S_DONE);
   assign dbg_state        = state_q;
endmodule

// File: tb/tb_cmac_block_fetcher.sv
// Bench for cmac_block_fetcher: one RD_LAT=1 and one RD_LAT=3 instance run the same
// directed messages in lockstep against a bench-built expected block queue.
module tb_cmac_block_fetcher;
   localparam int DW    = 128;
   localparam int AW    = 9;
   localparam int CW    = DW + 2;
   localparam int DEPTH = 4;

   logic           clk;
   logic           reset;
   logic           start;
   logic [15:0]    len;
   logic [AW-1:0]  base_addr;
   logic           blk_ready;
   logic           busy1, busy3, done1, done3;
   logic [1:0]     dbg1, dbg3;
   logic [DW-1:0]  p0, p1;

   cmac_block_fetcher_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
   cmac_block_fetcher_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();

   cmac_block_fetcher #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(16), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
      .bus(bus1), .busy(busy1), .done(done1), .dbg_state(dbg1));

   cmac_block_fetcher #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(16), .RD_LAT(3), .FIFO_DEPTH(DEPTH)) u_dut3 (
      .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
      .bus(bus3), .busy(busy3), .done(done3), .dbg_state(dbg3));

   // ---------------- clock / RAM models ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
      ram_word = {4{16'hC3A5, 7'd0, a}} ^ {32'h0, 32'h1234_5678, 32'h9abc_def0, 32'h0ff0_f00f};
   endfunction

   assign bus1.blk_ready = blk_ready;
   assign bus3.blk_ready = blk_ready;

   always @(posedge clk) if (bus1.ram_en) bus1.ram_rdata <= ram_word(bus1.ram_addr);

   always @(posedge clk) begin
      if (bus3.ram_en) p0 <= ram_word(bus3.ram_addr);
      p1             <= p0;
      bus3.ram_rdata <= p1;
   end

   logic          ram_en_w [2];
   logic [AW-1:0] ram_addr_w [2];
   logic          v_w [2], l_w [2], c_w [2], busy_w [2], done_w [2];
   logic [DW-1:0] d_w [2];
   logic [1:0]    dbg_w [2];

   assign ram_en_w[0] = bus1.ram_en;    assign ram_en_w[1] = bus3.ram_en;
   assign ram_addr_w[0] = bus1.ram_addr; assign ram_addr_w[1] = bus3.ram_addr;
   assign v_w[0] = bus1.blk_valid;      assign v_w[1] = bus3.blk_valid;
   assign l_w[0] = bus1.blk_last;       assign l_w[1] = bus3.blk_last;
   assign c_w[0] = bus1.blk_complete;   assign c_w[1] = bus3.blk_complete;
   assign d_w[0] = bus1.blk_data;       assign d_w[1] = bus3.blk_data;
   assign busy_w[0] = busy1;            assign busy_w[1] = busy3;
   assign done_w[0] = done1;            assign done_w[1] = done3;
   assign dbg_w[0] = dbg1;              assign dbg_w[1] = dbg3;

   // ---------------- scoreboard ----------------
   logic [CW-1:0] exp_q[$];
   logic [CW-1:0] prev_blk [2];
   int  pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
   int  ptr [2], pops [2], issued [2], rd_n [2], first_v [2];
   bit  done_pend [2], done_seen [2], prev_stall [2];
   int  msg_base = 0, exp_nb = 0, since = 0;

   task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      total_cnt++;
      assert (got === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] pad_blk(input logic [DW-1:0] d, input int r);
      logic [DW-1:0] o;
      o = '0;
      for (int b = 0; b < DW; b++) if (b >= DW - r) o[b] = d[b];
      o[DW-1-r] = 1'b1;
      return o;
   endfunction

   task automatic build_exp(input int b, input int l);
      int nb, r;
      logic [DW-1:0] w;
      exp_q.delete();
      nb = (l == 0) ? 1 : (l + DW - 1) / DW;
      r  = l % DW;
      for (int k = 0; k < nb; k++) begin
         w = (l == 0) ? '0 : ram_word(AW'((b + k) % 512));
         if (k != nb - 1) exp_q.push_back({2'b00, w});
         else if (r != 0 || l == 0) exp_q.push_back({2'b10, pad_blk(w, r)});
         else exp_q.push_back({2'b11, w});
      end
      exp_nb   = nb;
      msg_base = b;
      for (int i = 0; i < 2; i++) begin
         ptr[i] = 0; pops[i] = 0; issued[i] = 0; rd_n[i] = 0;
         first_v[i] = -1; done_seen[i] = 1'b0;
      end
   endtask

   task automatic observe();
      for (int i = 0; i < 2; i++) begin
         logic hs_last;
         hs_last = 1'b0;
         if (ram_en_w[i]) begin
            chk($sformatf("ram_addr%0d", i), CW'(ram_addr_w[i]), CW'((msg_base + rd_n[i]) % 512));
            rd_n[i]++;
            issued[i]++;
            chk($sformatf("credit%0d", i), CW'(issued[i] - pops[i] <= DEPTH), CW'(1));
         end
         if (prev_stall[i]) chk($sformatf("hold%0d", i), {v_w[i], l_w[i], c_w[i], d_w[i]}, {1'b1, prev_blk[i]});
         if (v_w[i]) begin
            if (first_v[i] < 0) first_v[i] = since;
            if (blk_ready) begin
               if (ptr[i] < exp_q.size()) begin
                  chk($sformatf("blk%0d_%0d", i, ptr[i]), {l_w[i], c_w[i], d_w[i]}, exp_q[ptr[i]]);
                  hs_last = l_w[i];
               end else begin
                  chk($sformatf("blk_count%0d", i), CW'(ptr[i] + 1), CW'(exp_q.size()));
               end
               ptr[i]++;
               pops[i]++;
            end
         end else begin
            chk($sformatf("idle_data%0d", i), CW'(d_w[i]), '0);
         end
         if (done_w[i] || done_pend[i]) begin
            chk($sformatf("done%0d", i), CW'(done_w[i]), CW'(done_pend[i]));
            if (done_w[i]) done_seen[i] = 1'b1;
         end
         done_pend[i]  = hs_last;
         prev_stall[i] = v_w[i] && !blk_ready;
         prev_blk[i]   = {l_w[i], c_w[i], d_w[i]};
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc();
      #1;
      observe();
      @(posedge clk);
      since++;
      #1;
   endtask

   task automatic chk_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_ram_en%0d", tag, i), CW'(ram_en_w[i]), '0);
         chk($sformatf("%s_ram_addr%0d", tag, i), CW'(ram_addr_w[i]), '0);
         chk($sformatf("%s_blk%0d", tag, i), {v_w[i], l_w[i], c_w[i], d_w[i][DW-1:1]}, '0);
         chk($sformatf("%s_busy_done%0d", tag, i), CW'({busy_w[i], done_w[i]}), '0);
         chk($sformatf("%s_state%0d", tag, i), CW'(dbg_w[i]), '0);
      end
   endtask

   task automatic run_msg(input int b, input int l, input bit rnd);
      build_exp(b, l);
      base_addr = AW'(b);
      len       = 16'(l);
      blk_ready = 1'b1;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      since = 0;
      for (int i = 0; i < 2; i++) chk($sformatf("busy_rise%0d", i), CW'(busy_w[i]), CW'(1));
      for (int c = 0; c < 20000 && !(done_seen[0] && done_seen[1]); c++) begin
         if (rnd) begin
            if (since >= 30 && since < 50) blk_ready = 1'b0;
            else blk_ready = 1'($urandom_range(0, 1));
            start = (since == 10);
            len   = (since == 10) ? 16'd128 : 16'(l);
         end
         cyc();
      end
      start     = 1'b0;
      blk_ready = 1'b1;
      chk($sformatf("finish_len%0d", l), CW'({done_seen[0], done_seen[1]}), CW'(2'b11));
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("nblk%0d_len%0d", i, l), CW'(pops[i]), CW'(exp_nb));
         chk($sformatf("nread%0d_len%0d", i, l), CW'(issued[i]), CW'((l == 0) ? 0 : exp_nb));
         if (l != 0) chk($sformatf("latency%0d", i), CW'(first_v[i]), CW'((i == 0) ? 3 : 5));
         chk($sformatf("busy_end%0d", i), CW'(busy_w[i]), '0);
      end
      cyc();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      len       = '0;
      base_addr = '0;
      blk_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      reset = 1'b1;
      cyc();
      cyc();

      run_msg(0, 256, 1'b0);
      run_msg(5, 264, 1'b0);
      run_msg(7, 0, 1'b0);
      run_msg(510, 512, 1'b0);
      run_msg(100, 34176, 1'b1);

      // Abort a message mid-flight, then make sure nothing stale leaks out.
      build_exp(20, 2048);
      base_addr = AW'(20);
      len       = 16'd2048;
      blk_ready = 1'b1;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      for (int c = 0; c < 200 && pops[0] < 5; c++) cyc();
      chk("mid_pops", CW'(pops[0]), CW'(5));
      reset = 1'b0;
      #1;
      chk_zero("mid_reset");
      repeat (3) cyc();
      chk_zero("held_reset");
      reset = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         done_pend[i]  = 1'b0;
         prev_stall[i] = 1'b0;
      end
      repeat (8) cyc();
      for (int i = 0; i < 2; i++) chk($sformatf("post_reset_quiet%0d", i), CW'({v_w[i], busy_w[i]}), '0);
      run_msg(30, 128, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
